regfile_wb_scoreboard: RTL and testbench
========================================

// Module: regfile_wb_scoreboard
// PURPOSE
//  Scheduler in front of the 8x16 CPU register file (r0 reads as zero, one write port).
//  Tracks in-flight destination registers (scoreboard) and stalls issue on RAW/WAW hazards.
//  Shares the single write port between two writeback requesters, ALU and load unit.
//  Sits between decode/issue and the register file; drives the file's wen/waddr/wdata.
// PARAMETERS
//  AW      3   register address width (2**AW registers, r0 hardwired zero)
//  DW      16  register data width
//  RR_EN   1   1 = round-robin writeback arbitration; 0 = fixed priority, MEM over ALU
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  rst          in   1      asynchronous active-high reset
//  issue_valid  in   1      decode presents an instruction
//  issue_rs0    in   AW     source register 0
//  issue_rs1    in   AW     source register 1
//  issue_rd     in   AW     destination register
//  issue_wen    in   1      instruction writes issue_rd
//  issue_stall  out  1      hazard; decode must hold its instruction
//  issue_fire   out  1      issue_valid & ~issue_stall; instruction accepted this cycle
//  alu_valid    in   1      ALU writeback request
//  alu_waddr    in   AW     ALU destination
//  alu_wdata    in   DW     ALU result
//  alu_ready    out  1      ALU request granted this cycle
//  mem_valid    in   1      load writeback request
//  mem_waddr    in   AW     load destination
//  mem_wdata    in   DW     load data
//  mem_ready    out  1      load request granted this cycle
//  rf_wen       out  1      register file write enable
//  rf_waddr     out  AW     register file write address
//  rf_wdata     out  DW     register file write data
//  busy_vec     out  2**AW  scoreboard bits, bit 0 always 0
//  wb_err       out  1      sticky: writeback to a non-busy register other than r0
// BEHAVIOUR
//  - Reset (async, any cycle): busy_vec=0, wb_err=0, last_grant=ALU; with no requests,
//    all handshake outputs and rf_wen are 0. Reset mid-transfer drops in-flight state.
//  - Stall (combinational, from registered busy only; no same-cycle release bypass):
//    issue_stall = issue_valid & (busy[rs0] | busy[rs1] | (issue_wen & busy[rd])).
//    r0 is never busy, so rs=0 never stalls.
//  - Issue: on issue_fire & issue_wen & rd!=0, busy[rd] set at the next edge.
//  - Writeback handshake: a request is complete in the cycle its ready is 1; the requester
//    holds valid/waddr/wdata stable until then. ready is combinational from valid, at most
//    one ready per cycle; zero-latency grant.
//  - Arbitration: one valid requester -> it is granted. Both valid: RR_EN=1 grants the side
//    not in last_grant; RR_EN=0 always grants MEM. last_grant updates only on a grant.
//  - Write port: rf_wen/rf_waddr/rf_wdata are a mux of the granted request. rf_wen=0 when
//    there is no grant or granted waddr=0; a waddr=0 handshake still completes.
//  - Release: granted waddr!=0 clears busy[waddr] at the same edge as the file write;
//    next-cycle issue reads the new value without stall.
//  - Same-cycle set and clear on one register cannot occur (WAW stall); set and clear on
//    different registers both take effect.
//  - wb_err sets on a grant with waddr!=0 and busy[waddr]=0; cleared only by rst.
// STRUCTURE
//  - Shared package regfile_pkg: AW, DW, NREGS=2**AW, grant encoding (GNT_ALU, GNT_MEM).
//  - Sub-module wb_rr_arbiter (2 requesters, RR_EN, last_grant register, one-hot grant);
//    scoreboard, stall logic and write-port mux stay in this module.
// TESTING
//  1 Reset: assert rst mid-run with busy_vec=8'h0C -> busy_vec=0, wb_err=0, rf_wen=0 at once.
//  2 RAW: issue rd=3, wen=1; next cycle issue rs0=3 -> stall until ALU wb r3=16'hBEEF granted;
//    stall drops the cycle after; rf_waddr=3, rf_wdata=16'hBEEF at the grant.
//  3 WAW: r5 busy, issue rd=5 with rs0=rs1=0 -> stall=1; no stall after MEM wb r5.
//  4 Contention, RR_EN=1: both valid 4 cycles (ALU r1, MEM r2, reissued) -> grants
//    MEM,ALU,MEM,ALU; RR_EN=0 -> MEM every cycle, alu_ready=0.
//  5 r0: issue rd=0 -> busy_vec unchanged; ALU wb r0 -> alu_ready=1, rf_wen=0, wb_err=0.
//  6 Error: MEM wb r6 while busy[6]=0 -> rf_wen=1, wb_err=1 and held until rst.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback scheduler: register
// geometry and the encoding used for the writeback grant.
package regfile_pkg;

    localparam int AW    = 3;
    localparam int DW    = 16;
    localparam int NREGS = 2 ** AW;

    // Index of each requester in the one-hot grant vector; also the value
    // stored in the arbiter's last-grant register.
    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } gnt_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-requester writeback arbiter (ALU, MEM) with one-hot zero-latency grant.
// RR_EN=1 alternates on contention; RR_EN=0 always favours MEM.
module wb_rr_arbiter
    import regfile_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_alu,
    input  logic       req_mem,
    output logic [1:0] gnt
);

    gnt_e last_grant_q;
    gnt_e last_grant_d;

    // Grant selection and last-grant bookkeeping; last grant moves only when someone is granted
    always_comb begin
        gnt          = 2'b00;
        last_grant_d = last_grant_q;
        if (req_alu && req_mem) begin
            if (RR_EN && (last_grant_q == GNT_MEM)) begin
                gnt[GNT_ALU] = 1'b1;
            end else begin
                gnt[GNT_MEM] = 1'b1;
            end
        end else if (req_alu) begin
            gnt[GNT_ALU] = 1'b1;
        end else if (req_mem) begin
            gnt[GNT_MEM] = 1'b1;
        end
        if (gnt[GNT_ALU]) begin
            last_grant_d = GNT_ALU;
        end else if (gnt[GNT_MEM]) begin
            last_grant_d = GNT_MEM;
        end
    end

    // Last-grant register; reset value makes MEM win the first contention under RR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GNT_ALU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Issue scoreboard and writeback-port scheduler in front of the 8x16 register
// file. Stalls issue on RAW/WAW hazards against in-flight destinations and
// shares the single write port between the ALU and the load unit.
module regfile_wb_scoreboard #(
    parameter int AW    = regfile_pkg::AW,
    parameter int DW    = regfile_pkg::DW,
    parameter bit RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rs0,
    input  logic [AW-1:0]     issue_rs1,
    input  logic [AW-1:0]     issue_rd,
    input  logic              issue_wen,
    output logic              issue_stall,
    output logic              issue_fire,
    input  logic              alu_valid,
    input  logic [AW-1:0]     alu_waddr,
    input  logic [DW-1:0]     alu_wdata,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [AW-1:0]     mem_waddr,
    input  logic [DW-1:0]     mem_wdata,
    output logic              mem_ready,
    output logic              rf_wen,
    output logic [AW-1:0]     rf_waddr,
    output logic [DW-1:0]     rf_wdata,
    output logic [2**AW-1:0]  busy_vec,
    output logic              wb_err
);

    localparam int NREGS = 2 ** AW;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             wb_err_q;
    logic             wb_err_d;
    logic [1:0]       gnt;
    logic             wb_grant;
    logic             wb_nonzero;

    wb_rr_arbiter #(
        .RR_EN (RR_EN)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_alu (alu_valid),
        .req_mem (mem_valid),
        .gnt     (gnt)
    );

    // Hazard check from registered busy bits only; a release in this cycle is seen next cycle
    always_comb begin
        issue_stall = issue_valid &
                      (busy_q[issue_rs0] | busy_q[issue_rs1] | (issue_wen & busy_q[issue_rd]));
        issue_fire  = issue_valid & ~issue_stall;
    end

    // Write-port mux of the granted request; r0 writes complete the handshake but never write
    always_comb begin
        alu_ready  = gnt[regfile_pkg::GNT_ALU];
        mem_ready  = gnt[regfile_pkg::GNT_MEM];
        wb_grant   = alu_ready | mem_ready;
        rf_waddr   = mem_ready ? mem_waddr : alu_waddr;
        rf_wdata   = mem_ready ? mem_wdata : alu_wdata;
        wb_nonzero = wb_grant & (rf_waddr != '0);
        rf_wen     = wb_nonzero;
    end

    // Scoreboard update: release on writeback, set on issue; WAW stall keeps them on different regs
    always_comb begin
        busy_d   = busy_q;
        wb_err_d = wb_err_q;
        if (wb_nonzero) begin
            busy_d[rf_waddr] = 1'b0;
            if (!busy_q[rf_waddr]) begin
                wb_err_d = 1'b1;
            end
        end
        if (issue_fire && issue_wen && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard and sticky error registers; reset drops all in-flight state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= '0;
            wb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign busy_vec = busy_q;
    assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed bench for regfile_wb_scoreboard: a per-cycle vector table for
// hazards, release, r0 and error cases, plus hand-written sequences for
// writeback contention (both arbitration modes) and asynchronous reset.
module tb_regfile_wb_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [2:0]  issue_rs0 = '0, issue_rs1 = '0, issue_rd = '0;
    logic        issue_wen = 1'b0;
    logic        alu_valid = 1'b0;
    logic [2:0]  alu_waddr = '0;
    logic [15:0] alu_wdata = '0;
    logic        mem_valid = 1'b0;
    logic [2:0]  mem_waddr = '0;
    logic [15:0] mem_wdata = '0;

    logic        issue_stall, issue_fire, alu_ready, mem_ready, rf_wen, wb_err;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [7:0]  busy_vec;

    logic        issue_stall0, issue_fire0, alu_ready0, mem_ready0, rf_wen0, wb_err0;
    logic [2:0]  rf_waddr0;
    logic [15:0] rf_wdata0;
    logic [7:0]  busy_vec0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb_scoreboard #(.AW(3), .DW(16), .RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs0(issue_rs0), .issue_rs1(issue_rs1),
        .issue_rd(issue_rd), .issue_wen(issue_wen),
        .issue_stall(issue_stall), .issue_fire(issue_fire),
        .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_vec(busy_vec), .wb_err(wb_err)
    );

    regfile_wb_scoreboard #(.AW(3), .DW(16), .RR_EN(1'b0)) dut_fixed (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs0(issue_rs0), .issue_rs1(issue_rs1),
        .issue_rd(issue_rd), .issue_wen(issue_wen),
        .issue_stall(issue_stall0), .issue_fire(issue_fire0),
        .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata), .alu_ready(alu_ready0),
        .mem_valid(mem_valid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_ready(mem_ready0),
        .rf_wen(rf_wen0), .rf_waddr(rf_waddr0), .rf_wdata(rf_wdata0),
        .busy_vec(busy_vec0), .wb_err(wb_err0)
    );

    typedef struct {
        logic        iv;
        logic [2:0]  rs0, rs1, rd;
        logic        iw;
        logic        av;
        logic [2:0]  aa;
        logic [15:0] ad;
        logic        mv;
        logic [2:0]  ma;
        logic [15:0] md;
        logic        stall, ardy, mrdy, wen;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic [7:0]  busy;
        logic        err;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [2:0] rs0, input logic [2:0] rs1,
                         input logic [2:0] rd, input logic iw,
                         input logic av, input logic [2:0] aa, input logic [15:0] ad,
                         input logic mv, input logic [2:0] ma, input logic [15:0] md);
        issue_valid = iv; issue_rs0 = rs0; issue_rs1 = rs1; issue_rd = rd; issue_wen = iw;
        alu_valid = av; alu_waddr = aa; alu_wdata = ad;
        mem_valid = mv; mem_waddr = ma; mem_wdata = md;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //            iv rs0 rs1 rd iw  av aa ad        mv ma md         stl ar mr wen wa wd        busy   err
        tbl[0]  = '{1, 0, 0, 3, 1,  0, 0, 16'h0000, 0, 0, 16'h0000,  0, 0, 0, 0, 0, 16'h0000, 8'h00, 0};
        tbl[1]  = '{1, 3, 0, 4, 0,  0, 0, 16'h0000, 0, 0, 16'h0000,  1, 0, 0, 0, 0, 16'h0000, 8'h08, 0};
        tbl[2]  = '{1, 3, 0, 4, 0,  1, 3, 16'hBEEF, 0, 0, 16'h0000,  1, 1, 0, 1, 3, 16'hBEEF, 8'h08, 0};
        tbl[3]  = '{1, 3, 0, 4, 0,  0, 0, 16'h0000, 0, 0, 16'h0000,  0, 0, 0, 0, 0, 16'h0000, 8'h00, 0};
        tbl[4]  = '{1, 0, 0, 5, 1,  0, 0, 16'h0000, 0, 0, 16'h0000,  0, 0, 0, 0, 0, 16'h0000, 8'h00, 0};
        tbl[5]  = '{1, 0, 0, 5, 1,  0, 0, 16'h0000, 0, 0, 16'h0000,  1, 0, 0, 0, 0, 16'h0000, 8'h20, 0};
        tbl[6]  = '{1, 0, 0, 5, 1,  0, 0, 16'h0000, 1, 5, 16'h1234,  1, 0, 1, 1, 5, 16'h1234, 8'h20, 0};
        tbl[7]  = '{1, 0, 0, 5, 1,  0, 0, 16'h0000, 0, 0, 16'h0000,  0, 0, 0, 0, 0, 16'h0000, 8'h00, 0};
        tbl[8]  = '{1, 0, 0, 0, 1,  1, 0, 16'hAAAA, 0, 0, 16'h0000,  0, 1, 0, 0, 0, 16'h0000, 8'h20, 0};
        tbl[9]  = '{0, 0, 0, 0, 0,  0, 0, 16'h0000, 1, 5, 16'h0005,  0, 0, 1, 1, 5, 16'h0005, 8'h20, 0};
        tbl[10] = '{0, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 0, 16'h0000,  0, 0, 0, 0, 0, 16'h0000, 8'h00, 0};
        tbl[11] = '{0, 0, 0, 0, 0,  0, 0, 16'h0000, 1, 6, 16'h6666,  0, 0, 1, 1, 6, 16'h6666, 8'h00, 0};
        tbl[12] = '{0, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 0, 16'h0000,  0, 0, 0, 0, 0, 16'h0000, 8'h00, 1};
        tbl[13] = '{1, 0, 0, 2, 1,  0, 0, 16'h0000, 0, 0, 16'h0000,  0, 0, 0, 0, 0, 16'h0000, 8'h00, 1};
        tbl[14] = '{0, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 0, 16'h0000,  0, 0, 0, 0, 0, 16'h0000, 8'h04, 1};
        tbl[15] = '{1, 0, 0, 1, 1,  1, 2, 16'h2222, 0, 0, 16'h0000,  0, 1, 0, 1, 2, 16'h2222, 8'h04, 1};
        tbl[16] = '{0, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 0, 16'h0000,  0, 0, 0, 0, 0, 16'h0000, 8'h02, 1};

        // Reset state
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy_vec, 8'h00);
        chk("rst_err", wb_err, 1'b0);
        chk("rst_rfwen", rf_wen, 1'b0);
        chk("rst_ardy", alu_ready, 1'b0);
        chk("rst_mrdy", mem_ready, 1'b0);
        chk("rst_stall", issue_stall, 1'b0);
        chk("rst_fire", issue_fire, 1'b0);
        #3 rst = 1'b0;

        // Table: RAW, WAW, r0, error, set/clear on different regs
        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].iv, tbl[i].rs0, tbl[i].rs1, tbl[i].rd, tbl[i].iw,
                  tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].mv, tbl[i].ma, tbl[i].md);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), issue_stall, tbl[i].stall);
            chk($sformatf("v%0d_fire", i), issue_fire, tbl[i].iv & ~tbl[i].stall);
            chk($sformatf("v%0d_ardy", i), alu_ready, tbl[i].ardy);
            chk($sformatf("v%0d_mrdy", i), mem_ready, tbl[i].mrdy);
            chk($sformatf("v%0d_rfwen", i), rf_wen, tbl[i].wen);
            if (tbl[i].wen) begin
                chk($sformatf("v%0d_waddr", i), rf_waddr, tbl[i].waddr);
                chk($sformatf("v%0d_wdata", i), rf_wdata, tbl[i].wdata);
            end
            chk($sformatf("v%0d_busy", i), busy_vec, tbl[i].busy);
            chk($sformatf("v%0d_err", i), wb_err, tbl[i].err);
        end

        // Contention: both requesters valid for four cycles
        @(posedge clk);
        #1 idle();
        rst = 1'b1;
        #2 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1 drive(0, 0, 0, 0, 0, 1, 1, 16'h0101, 1, 2, 16'h0202);
            @(negedge clk);
            chk($sformatf("rr%0d_mrdy", c), mem_ready, (c % 2) == 0);
            chk($sformatf("rr%0d_ardy", c), alu_ready, (c % 2) == 1);
            chk($sformatf("rr%0d_waddr", c), rf_waddr, ((c % 2) == 0) ? 3'd2 : 3'd1);
            chk($sformatf("rr%0d_wdata", c), rf_wdata, ((c % 2) == 0) ? 16'h0202 : 16'h0101);
            chk($sformatf("fix%0d_mrdy", c), mem_ready0, 1'b1);
            chk($sformatf("fix%0d_ardy", c), alu_ready0, 1'b0);
            chk($sformatf("fix%0d_waddr", c), rf_waddr0, 3'd2);
        end

        // Asynchronous reset mid-run with r2 and r3 in flight and wb_err set
        @(posedge clk);
        #1 drive(1, 0, 0, 2, 1, 0, 0, 16'h0, 0, 0, 16'h0);
        @(posedge clk);
        #1 drive(1, 0, 0, 3, 1, 0, 0, 16'h0, 0, 0, 16'h0);
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        chk("pre_rst_busy", busy_vec, 8'h0C);
        chk("pre_rst_err", wb_err, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", busy_vec, 8'h00);
        chk("async_rst_err", wb_err, 1'b0);
        chk("async_rst_rfwen", rf_wen, 1'b0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy_vec, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
